// File: rtl/change_dispenser.sv
// Greedy coin payout: 500 coins first, then 100 coins, one registered eject pulse at a time.
// Optional COFFEE_CHANGE_COUNT_EN enables saturating per-hopper eject counters.
module change_dispenser #(
  parameter int AMT_W      = 7,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             change_valid,
  input  logic [AMT_W-1:0] change_amount,
  output logic             change_ready,
  input  logic             hopper_ready,
  input  logic             empty_500,
  input  logic             empty_100,
  output logic             eject_500,
  output logic             eject_100,
  output logic [AMT_W-1:0] remaining,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [15:0]      count_500,
  output logic [15:0]      count_100
);

  typedef enum logic [2:0] {S_IDLE, S_EJECT, S_GAP, S_DONE, S_FAULT} state_t;

  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_t           state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [3:0]       gap_q, gap_d;
  logic             eject_500_q, eject_500_d;
  logic             eject_100_q, eject_100_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    gap_d       = gap_q;
    eject_500_d = 1'b0;
    eject_100_d = 1'b0;
    done_d      = 1'b0;
    fault_d     = fault_q;
    case (state_q)
      S_IDLE: begin
        if (change_valid && ready_q) begin
          remaining_d = change_amount;
          state_d     = S_EJECT;
        end
      end
      S_EJECT: begin
        if (remaining_q == '0) begin
          state_d = S_DONE;
        end else if (hopper_ready) begin
          if (remaining_q >= AMT_W'(5) && !empty_500) begin
            eject_500_d = 1'b1;
            remaining_d = remaining_q - AMT_W'(5);
          end else if (!empty_100) begin
            eject_100_d = 1'b1;
            remaining_d = remaining_q - AMT_W'(1);
          end else begin
            state_d = S_FAULT;
          end
          // Settle gap after every coin unless the amount is now fully paid.
          if (eject_500_d || eject_100_d) begin
            if (remaining_d == '0) begin
              state_d = S_DONE;
            end else if (GAP_CYCLES > 0) begin
              state_d = S_GAP;
              gap_d   = 4'(GAP_LOAD);
            end
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_EJECT;
        else             gap_d   = gap_q - 4'd1;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_FAULT: fault_d = 1'b1;
      default: state_d = S_IDLE;
    endcase
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      gap_q       <= '0;
      eject_500_q <= 1'b0;
      eject_100_q <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      gap_q       <= gap_d;
      eject_500_q <= eject_500_d;
      eject_100_q <= eject_100_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

`ifdef COFFEE_CHANGE_COUNT_EN
  logic [15:0] count_500_q, count_500_d;
  logic [15:0] count_100_q, count_100_d;

  always_comb begin
    count_500_d = count_500_q;
    count_100_d = count_100_q;
    if (eject_500_d && count_500_q != 16'hFFFF) count_500_d = count_500_q + 16'd1;
    if (eject_100_d && count_100_q != 16'hFFFF) count_100_d = count_100_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_500_q <= '0;
      count_100_q <= '0;
    end else begin
      count_500_q <= count_500_d;
      count_100_q <= count_100_d;
    end
  end

  assign count_500 = count_500_q;
  assign count_100 = count_100_q;
`else
  assign count_500 = '0;
  assign count_100 = '0;
`endif

  assign change_ready = ready_q;
  assign eject_500    = eject_500_q;
  assign eject_100    = eject_100_q;
  assign remaining    = remaining_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus randomized payouts
// checked against an arithmetic greedy model.
module tb_change_dispenser;
  localparam int AW = 7;
  localparam int G  = 2;
  localparam int MAXC = 512;

  logic          clock = 1'b0;
  logic          reset, change_valid, hopper_ready, empty_500, empty_100;
  logic [AW-1:0] change_amount;
  logic          change_ready, eject_500, eject_100, busy, done, fault;
  logic [AW-1:0] remaining;
  logic [15:0]   count_500, count_100;

  change_dispenser #(.AMT_W(AW), .GAP_CYCLES(G)) dut (
    .clock(clock), .reset(reset), .change_valid(change_valid), .change_amount(change_amount),
    .change_ready(change_ready), .hopper_ready(hopper_ready), .empty_500(empty_500),
    .empty_100(empty_100), .eject_500(eject_500), .eject_100(eject_100), .remaining(remaining),
    .busy(busy), .done(done), .fault(fault), .count_500(count_500), .count_100(count_100)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0;
  int exp_c5 = 0, exp_c1 = 0;
  logic cap_e5 [0:MAXC-1];
  logic cap_e1 [0:MAXC-1];
  logic cap_dn [0:MAXC-1];
  logic cap_ft [0:MAXC-1];
  logic cap_rd [0:MAXC-1];
  int   cap_rm [0:MAXC-1];

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; change_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    exp_c5 = 0; exp_c1 = 0;
  endtask

  task automatic sample(input int c);
    cap_e5[c] = eject_500; cap_e1[c] = eject_100; cap_dn[c] = done;
    cap_ft[c] = fault; cap_rd[c] = change_ready; cap_rm[c] = int'(remaining);
  endtask

  // Handshake at edge 0; cycle c is observed just after edge c.
  task automatic request_capture(input int amt, input int ncyc);
    @(negedge clock);
    change_valid = 1'b1; change_amount = AW'(amt);
    @(posedge clock);
    @(negedge clock);
    change_valid = 1'b0;
    sample(0);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clock);
      sample(c);
    end
  endtask

  // Greedy payout from the rules: how many of each coin, and whether it stalls.
  task automatic model(input int amt, input bit e5, input bit e1,
                       output int n5, output int n1, output bit flt);
    flt = 1'b0;
    if (e5) begin
      n5 = 0;
      if (e1) begin n1 = 0; flt = (amt > 0); end
      else n1 = amt;
    end else begin
      n5 = amt / 5;
      if (e1) begin n1 = 0; flt = (amt % 5) != 0; end
      else n1 = amt % 5;
    end
  endtask

  function automatic int first_high(input int ncyc, input bit which_done);
    for (int c = 0; c <= ncyc; c++)
      if (which_done ? cap_dn[c] : cap_ft[c]) return c;
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b1; change_valid = 1'b0; change_amount = '0;
    hopper_ready = 1'b1; empty_500 = 1'b0; empty_100 = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({change_ready, eject_500, eject_100, busy, done, fault} !== 6'b100000 ||
        remaining !== '0 || count_500 !== 16'd0 || count_100 !== 16'd0) begin
      failures++;
      $display("FAIL reset_state: got ready=%0b e5=%0b e1=%0b busy=%0b done=%0b fault=%0b rem=%0d c5=%0d c1=%0d, want ready=1 rest 0",
               change_ready, eject_500, eject_100, busy, done, fault, remaining, count_500, count_100);
    end
    reset = 1'b0;
  endtask

  task automatic test_greedy();
    do_reset();
    request_capture(7, 12);
    exp_c5 += 1; exp_c1 += 2;
    for (int c = 1; c <= 12; c++) begin
      bit w5, w1;
      w5 = (c == 1); w1 = (c == 4 || c == 7);
      checks++;
      if (cap_e5[c] !== w5 || cap_e1[c] !== w1) begin
        failures++;
        $display("FAIL greedy_pulse c=%0d: got e5=%0b e1=%0b want e5=%0b e1=%0b", c, cap_e5[c], cap_e1[c], w5, w1);
      end
    end
    checks++;
    if (cap_rm[1] !== 2 || cap_rm[4] !== 1 || cap_rm[7] !== 0) begin
      failures++;
      $display("FAIL greedy_remaining: got %0d,%0d,%0d want 2,1,0", cap_rm[1], cap_rm[4], cap_rm[7]);
    end
    checks++;
    if (first_high(12, 1'b1) !== 8 || cap_rd[8] !== 1'b1) begin
      failures++;
      $display("FAIL greedy_done: got cycle %0d ready=%0b want cycle 8 ready=1", first_high(12, 1'b1), cap_rd[8]);
    end
    request_capture(0, 5);
    checks++;
    begin
      int np = 0;
      for (int c = 0; c <= 5; c++) np += int'(cap_e5[c]) + int'(cap_e1[c]);
      if (np != 0 || first_high(5, 1'b1) !== 2) begin
        failures++;
        $display("FAIL zero_amount: got pulses=%0d done_cycle=%0d want 0 and 2", np, first_high(5, 1'b1));
      end
    end
  endtask

  task automatic test_empty_500();
    do_reset();
    empty_500 = 1'b1;
    request_capture(6, 22);
    exp_c1 += 6;
    for (int c = 1; c <= 20; c++) begin
      bit w1;
      w1 = ((c - 1) % 3 == 0) && c <= 16;
      checks++;
      if (cap_e5[c] !== 1'b0 || cap_e1[c] !== w1) begin
        failures++;
        $display("FAIL empty500_pulse c=%0d: got e5=%0b e1=%0b want e5=0 e1=%0b", c, cap_e5[c], cap_e1[c], w1);
      end
    end
    checks++;
    if (first_high(22, 1'b1) !== 17 || first_high(22, 1'b0) !== -1) begin
      failures++;
      $display("FAIL empty500_done: got done=%0d fault=%0d want 17 and -1", first_high(22, 1'b1), first_high(22, 1'b0));
    end
    empty_500 = 1'b0;
  endtask

  task automatic test_fault();
    do_reset();
    empty_100 = 1'b1;
    request_capture(3, 10);
    checks++;
    begin
      int np = 0, nr = 0;
      for (int c = 0; c <= 10; c++) begin
        np += int'(cap_e5[c]) + int'(cap_e1[c]);
        nr += int'(cap_rd[c]);
      end
      if (first_high(10, 1'b0) !== 2 || cap_rm[10] !== 3 || np != 0 || nr != 0) begin
        failures++;
        $display("FAIL fault_small: got fault_cycle=%0d rem=%0d pulses=%0d ready_cycles=%0d want 2,3,0,0",
                 first_high(10, 1'b0), cap_rm[10], np, nr);
      end
    end
    do_reset();
    empty_100 = 1'b1;
    request_capture(8, 10);
    checks++;
    if (cap_e5[1] !== 1'b1 || first_high(10, 1'b0) !== 5 || cap_rm[10] !== 3) begin
      failures++;
      $display("FAIL fault_after_500: got e5@1=%0b fault_cycle=%0d rem=%0d want 1,5,3",
               cap_e5[1], first_high(10, 1'b0), cap_rm[10]);
    end
    empty_100 = 1'b0;
    do_reset();
  endtask

  task automatic test_backpressure();
    int np = 0;
    do_reset();
    hopper_ready = 1'b0;
    @(negedge clock);
    change_valid = 1'b1; change_amount = AW'(5);
    @(posedge clock);
    @(negedge clock);
    change_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      np += int'(eject_500) + int'(eject_100);
    end
    hopper_ready = 1'b1;
    checks++;
    if (np != 0 || fault !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_hold: got pulses=%0d fault=%0b want 0,0", np, fault);
    end
    @(negedge clock);
    checks++;
    if (eject_500 !== 1'b1 || remaining !== '0) begin
      failures++;
      $display("FAIL backpressure_release: got e5=%0b rem=%0d want 1,0", eject_500, remaining);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_done: got done=%0b want 1", done);
    end
    exp_c5 += 1;
  endtask

  task automatic test_reset_mid();
    int np = 0;
    do_reset();
    @(negedge clock);
    change_valid = 1'b1; change_amount = AW'(20);
    @(posedge clock);
    @(negedge clock);
    change_amount = AW'(3);  // held valid while busy must be ignored
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      if (c == 1) begin
        checks++;
        if (eject_500 !== 1'b1 || remaining !== AW'(15)) begin
          failures++;
          $display("FAIL busy_ignore_1: got e5=%0b rem=%0d want 1,15", eject_500, remaining);
        end
      end
    end
    checks++;
    if (eject_500 !== 1'b1 || remaining !== AW'(10)) begin
      failures++;
      $display("FAIL busy_ignore_2: got e5=%0b rem=%0d want 1,10", eject_500, remaining);
    end
    change_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({change_ready, eject_500, eject_100, busy, done, fault} !== 6'b100000 || remaining !== '0 ||
        count_500 !== 16'd0 || count_100 !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid: got ready=%0b e5=%0b e1=%0b busy=%0b done=%0b fault=%0b rem=%0d",
               change_ready, eject_500, eject_100, busy, done, fault, remaining);
    end
    reset = 1'b0; exp_c5 = 0; exp_c1 = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      np += int'(eject_500) + int'(eject_100) + int'(busy);
    end
    checks++;
    if (np != 0) begin
      failures++;
      $display("FAIL reset_mid_quiet: got %0d pulse/busy cycles want 0", np);
    end
  endtask

  task automatic test_counters();
    int w5, w1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      request_capture(7, 9);
      exp_c5 += 1; exp_c1 += 2;
    end
`ifdef COFFEE_CHANGE_COUNT_EN
    w5 = exp_c5; w1 = exp_c1;
`else
    w5 = 0; w1 = 0;
`endif
    checks++;
    if (int'(count_500) != w5 || int'(count_100) != w1) begin
      failures++;
      $display("FAIL counters: got c5=%0d c1=%0d want %0d,%0d", count_500, count_100, w5, w1);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      int amt, n5, n1, n, ncyc, bad, wd, wf, wr;
      bit e5, e1, flt;
      amt = (it == 0) ? 127 : int'($urandom_range(0, 40));
      e5 = ($urandom_range(0, 3) == 0);
      e1 = ($urandom_range(0, 3) == 0);
      model(amt, e5, e1, n5, n1, flt);
      n = n5 + n1;
      ncyc = n * (G + 1) + 6;
      empty_500 = e5; empty_100 = e1; hopper_ready = 1'b1;
      request_capture(amt, ncyc);
      bad = -1;
      for (int c = 1; c <= ncyc; c++) begin
        bit p, w5, w1;
        int idx;
        idx = (c - 1) / (G + 1);
        p = ((c - 1) % (G + 1) == 0) && idx < n;
        w5 = p && idx < n5;
        w1 = p && idx >= n5;
        wr = amt - 5 * ((idx + 1 < n5) ? idx + 1 : n5) - ((idx + 1 - n5 > 0) ? idx + 1 - n5 : 0);
        if (bad < 0 && (cap_e5[c] !== w5 || cap_e1[c] !== w1 || (p && cap_rm[c] != wr))) bad = c;
      end
      checks++;
      if (bad >= 0) begin
        failures++;
        $display("FAIL rand_trace amt=%0d e5=%0b e1=%0b: first bad cycle %0d got e5=%0b e1=%0b rem=%0d",
                 amt, e5, e1, bad, cap_e5[bad], cap_e1[bad], cap_rm[bad]);
      end
      wd = flt ? -1 : ((n == 0) ? 2 : (n - 1) * (G + 1) + 2);
      wf = flt ? n * (G + 1) + 2 : -1;
      checks++;
      if (first_high(ncyc, 1'b1) != wd || first_high(ncyc, 1'b0) != wf || cap_rm[ncyc] != amt - 5 * n5 - n1) begin
        failures++;
        $display("FAIL rand_end amt=%0d e5=%0b e1=%0b: got done=%0d fault=%0d rem=%0d want %0d,%0d,%0d",
                 amt, e5, e1, first_high(ncyc, 1'b1), first_high(ncyc, 1'b0), cap_rm[ncyc],
                 wd, wf, amt - 5 * n5 - n1);
      end
      if (flt) do_reset();
    end
    empty_500 = 1'b0; empty_100 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_greedy();
    test_empty_500();
    test_fault();
    test_backpressure();
    test_reset_mid();
    test_counters();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
